hdmi_to_blocks_pp: RTL

- Parametrised successor of the HDMI-to-block converter.
- Accepts a raster YCbCr stream (N pixels/clk, CH channels) and buffers one stripe of BLK lines in a ping-pong line buffer.
- Emits BLKxBLK blocks in block order, N pixels/clk, with sob/eob/sof/eof framing and sync-error reporting.
- Sits between the HDMI receiver and the JPEG DCT/quantiser pipeline.

---
 rtl/hdmi_to_blocks_pp.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_to_blocks_pp.sv
// Raster YCbCr to BLKxBLK block converter. One stripe of BLK lines is buffered per
// ping-pong bank and replayed in block order with sob/eob/sof/eof framing.
module hdmi_to_blocks_pp #(
    parameter int unsigned N     = 2,
    parameter int unsigned CH    = 3,
    parameter int unsigned BLK   = 8,
    parameter int unsigned X_RES = 2160,
    parameter int unsigned Y_RES = 1200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                hdmi_v_sync,
    input  logic                hdmi_h_sync,
    input  logic                hdmi_data_valid,
    input  logic [CH*N*8-1:0]   hdmi_data,
    output logic                blk_valid,
    output logic [CH*N*8-1:0]   blk_data,
    output logic                blk_sob,
    output logic                blk_eob,
    output logic                blk_sof,
    output logic                blk_eof,
    output logic [1:0]          err
);
    localparam int unsigned W     = CH * N * 8;
    localparam int unsigned XW    = X_RES / N;
    localparam int unsigned CPB   = BLK / N;
    localparam int unsigned NB    = X_RES / BLK;
    localparam int unsigned NS    = Y_RES / BLK;
    localparam int unsigned DEPTH = 2 * BLK * XW;
    localparam int unsigned XB    = (XW > 1) ? $clog2(XW) : 1;
    localparam int unsigned RB    = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int unsigned SB    = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned CB    = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned BB    = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RdIdle, RdBusy} rd_state_t;

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data;

    logic [XB-1:0] wr_x;
    logic [RB-1:0] wr_row;
    logic [SB-1:0] wr_stripe;
    logic          wr_bank;

    rd_state_t     rd_state;
    logic          rd_bank;
    logic [SB-1:0] rd_stripe;
    logic [BB-1:0] rd_blk;
    logic [RB-1:0] rd_r;
    logic [CB-1:0] rd_c;

    logic s1_valid, s1_sob, s1_eob, s1_sof, s1_eof;

    // Write-side next state; v_sync rebases first, then h_sync, then the data word.
    logic [XB-1:0] base_x, x_mid, x_nxt;
    logic [RB-1:0] base_row, row_nxt;
    logic [SB-1:0] base_stripe, stripe_nxt;
    logic          base_bank, bank_nxt;
    logic          short_line, line_end, swap;
    logic [AW-1:0] wr_addr;

    always_comb begin
        base_x      = wr_x;
        base_row    = wr_row;
        base_stripe = wr_stripe;
        base_bank   = wr_bank;
        if (hdmi_v_sync) begin
            base_x      = '0;
            base_row    = '0;
            base_stripe = '0;
            base_bank   = 1'b0;
        end
        short_line = hdmi_h_sync && (base_x != '0);
        x_mid      = short_line ? '0 : base_x;
        line_end   = hdmi_data_valid && (x_mid == XB'(XW - 1));
        x_nxt      = x_mid;
        if (hdmi_data_valid) begin
            x_nxt = line_end ? '0 : x_mid + 1'b1;
        end
        row_nxt    = base_row;
        stripe_nxt = base_stripe;
        bank_nxt   = base_bank;
        swap       = 1'b0;
        if (short_line || line_end) begin
            if (base_row == RB'(BLK - 1)) begin
                row_nxt    = '0;
                swap       = 1'b1;
                bank_nxt   = ~base_bank;
                stripe_nxt = (base_stripe == SB'(NS - 1)) ? '0 : base_stripe + 1'b1;
            end else begin
                row_nxt = base_row + 1'b1;
            end
        end
        wr_addr = AW'((32'(base_bank) * BLK + 32'(base_row)) * XW + 32'(x_mid));
    end

    logic          rd_busy, rd_last;
    logic          cur_sob, cur_eob, cur_sof, cur_eof;
    logic [AW-1:0] rd_addr;

    always_comb begin
        rd_busy = (rd_state == RdBusy);
        cur_sob = (rd_r == '0) && (rd_c == '0);
        cur_eob = (rd_r == RB'(BLK - 1)) && (rd_c == CB'(CPB - 1));
        cur_sof = cur_sob && (rd_blk == '0) && (rd_stripe == '0);
        cur_eof = cur_eob && (rd_blk == BB'(NB - 1)) && (rd_stripe == SB'(NS - 1));
        rd_last = rd_busy && cur_eob && (rd_blk == BB'(NB - 1));
        rd_addr = AW'((32'(rd_bank) * BLK + 32'(rd_r)) * XW
                      + 32'(rd_blk) * CPB + 32'(rd_c));
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (hdmi_data_valid) begin
                mem[wr_addr] <= hdmi_data;
            end
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_x      <= '0;
            wr_row    <= '0;
            wr_stripe <= '0;
            wr_bank   <= 1'b0;
            rd_state  <= RdIdle;
            rd_bank   <= 1'b0;
            rd_stripe <= '0;
            rd_blk    <= '0;
            rd_r      <= '0;
            rd_c      <= '0;
            s1_valid  <= 1'b0;
            s1_sob    <= 1'b0;
            s1_eob    <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eof    <= 1'b0;
            blk_valid <= 1'b0;
            blk_data  <= '0;
            blk_sob   <= 1'b0;
            blk_eob   <= 1'b0;
            blk_sof   <= 1'b0;
            blk_eof   <= 1'b0;
            err       <= 2'b00;
        end else if (en) begin
            wr_x      <= x_nxt;
            wr_row    <= row_nxt;
            wr_stripe <= stripe_nxt;
            wr_bank   <= bank_nxt;
            if (short_line) begin
                err[1] <= 1'b1;
            end
            // A swap on the reader's final word hands over back-to-back, not an overflow.
            if (swap && rd_busy && !rd_last) begin
                err[0] <= 1'b1;
            end

            s1_valid <= rd_busy;
            s1_sob   <= cur_sob;
            s1_eob   <= cur_eob;
            s1_sof   <= cur_sof;
            s1_eof   <= cur_eof;

            if (swap) begin
                rd_state  <= RdBusy;
                rd_bank   <= base_bank;
                rd_stripe <= base_stripe;
                rd_blk    <= '0;
                rd_r      <= '0;
                rd_c      <= '0;
            end else if (rd_busy) begin
                if (rd_c == CB'(CPB - 1)) begin
                    rd_c <= '0;
                    if (rd_r == RB'(BLK - 1)) begin
                        rd_r   <= '0;
                        rd_blk <= (rd_blk == BB'(NB - 1)) ? '0 : rd_blk + 1'b1;
                    end else begin
                        rd_r <= rd_r + 1'b1;
                    end
                end else begin
                    rd_c <= rd_c + 1'b1;
                end
                if (rd_last) begin
                    rd_state <= RdIdle;
                end
            end

            blk_valid <= s1_valid;
            blk_data  <= rd_data;
            blk_sob   <= s1_valid && s1_sob;
            blk_eob   <= s1_valid && s1_eob;
            blk_sof   <= s1_valid && s1_sof;
            blk_eof   <= s1_valid && s1_eof;
        end
    end

endmodule
